uart_cmd_fifo_wrapper: RTL and testbench



---
 rtl/uart_cmd_fifo_wrapper.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_fifo_wrapper.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_fifo_wrapper.sv
// Command/response framing between a UART and the command processor: multi-byte
// commands queued in a first-word-fall-through FIFO, multi-byte responses serialised MSB first.

module uart #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(CLKS_PER_BIT / 2);

    logic [9:0]    tx_sr;
    logic [BW-1:0] tx_baud;
    logic [3:0]    tx_bits;
    logic          tx_busy;

    // Frame is {stop, data, start}, shifted out LSB first; ones refill so the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '1;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else if (trmt) begin
            tx_sr   <= {1'b1, tx_data, 1'b0};
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b1;
            tx_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_baud == BIT_LAST) begin
                tx_baud <= '0;
                tx_sr   <= {1'b1, tx_sr[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + BW'(1);
            end
        end
    end

    assign TX = tx_sr[0];

    logic          rx_meta, rx_s, rx_busy;
    logic [BW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_sr;

    // Start edge preloads the baud counter to half a bit so every sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bits <= '0;
            rx_sr   <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_baud <= BIT_HALF;
                    rx_bits <= '0;
                end
            end else if (rx_baud == BIT_LAST) begin
                rx_baud <= '0;
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd0) begin
                    if (rx_s)
                        rx_busy <= 1'b0;
                end else if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s)
                        rx_rdy <= 1'b1;
                end else begin
                    rx_sr <= {rx_s, rx_sr[7:1]};
                end
            end else begin
                rx_baud <= rx_baud + BW'(1);
            end
        end
    end

    assign rx_data = rx_sr;
endmodule

module uart_cmd_fifo_wrapper #(
    parameter int CMD_BYTES    = 2,
    parameter int RESP_BYTES   = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 2_500_000,
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    output logic                    TX,
    input  logic                    clr_cmd_rdy,
    output logic                    cmd_rdy,
    output logic [8*CMD_BYTES-1:0]  cmd,
    input  logic                    trmt,
    input  logic [8*RESP_BYTES-1:0] resp,
    output logic                    tx_done,
    output logic                    resp_busy,
    output logic                    cmd_ovf,
    output logic                    rx_timeout
);
    localparam int CW  = 8 * CMD_BYTES;
    localparam int RW  = 8 * RESP_BYTES;
    localparam int BCW = $clog2(CMD_BYTES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TW  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int RBW = $clog2(RESP_BYTES + 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(CMD_BYTES - 1);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
    localparam logic [RBW-1:0] RB_LAST = RBW'(RESP_BYTES - 1);

    // Handshakes: a level *_rdy flag is held by its producer until the consumer pulses clr_*
    // for one clock; the UART byte flag is acknowledged in the same cycle it is seen.
    logic       uart_rx_rdy, uart_trmt, uart_tx_done;
    logic [7:0] uart_rx_data, uart_tx_data;

    uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (uart_rx_rdy),
        .clr_rx_rdy (uart_rx_rdy),
        .rx_data    (uart_rx_data),
        .trmt       (uart_trmt),
        .tx_data    (uart_tx_data),
        .tx_done    (uart_tx_done)
    );

    logic [CW-1:0]  cmd_sr, new_word;
    logic [BCW-1:0] byte_cnt;
    logic [TW-1:0]  idle_cnt;
    logic           push, expire;

    assign new_word = (cmd_sr << 8) | CW'(uart_rx_data);
    assign push     = uart_rx_rdy && (byte_cnt == BC_LAST);
    assign expire   = (TIMEOUT_CLKS != 0) && !uart_rx_rdy && (byte_cnt != '0) && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sr     <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= 1'b0;
            if (uart_rx_rdy) begin
                idle_cnt <= '0;
                cmd_sr   <= new_word;
                byte_cnt <= push ? '0 : byte_cnt + BCW'(1);
            end else if (expire) begin
                idle_cnt   <= '0;
                cmd_sr     <= '0;
                byte_cnt   <= '0;
                rx_timeout <= 1'b1;
            end else if (byte_cnt != '0) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    logic [CW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop     = clr_cmd_rdy && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cmd_ovf <= 1'b0;
        end else begin
            cmd_ovf <= push && full && !pop;
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= new_word;
    end

    assign cmd_rdy = !empty;
    assign cmd     = mem[rd_ptr];

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
    tx_state_t      state, state_nxt;
    logic [RW-1:0]  resp_sr;
    logic [RBW-1:0] bytes_left;

    always_comb begin
        state_nxt = state;
        uart_trmt = 1'b0;
        case (state)
            TX_IDLE: if (trmt) state_nxt = TX_SEND;
            TX_SEND: begin
                uart_trmt = 1'b1;
                state_nxt = TX_WAIT;
            end
            TX_WAIT: if (uart_tx_done) state_nxt = (bytes_left != '0) ? TX_SEND : TX_IDLE;
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            resp_sr    <= '0;
            bytes_left <= '0;
            tx_done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == TX_IDLE && trmt) begin
                resp_sr    <= resp;
                bytes_left <= RB_LAST;
                tx_done    <= 1'b0;
            end else if (state == TX_WAIT && uart_tx_done) begin
                if (bytes_left != '0) begin
                    resp_sr    <= resp_sr << 8;
                    bytes_left <= bytes_left - RBW'(1);
                end else begin
                    tx_done <= 1'b1;
                end
            end
        end
    end

    assign uart_tx_data = resp_sr[RW-1 -: 8];
    assign resp_busy    = (state != TX_IDLE);
endmodule

// File: tb/tb_uart_cmd_fifo_wrapper.sv
// Directed bench for uart_cmd_fifo_wrapper: serial byte driver, TX line decoder,
// table-driven command/response vectors and hand-written corner sequences.

module tb_uart_cmd_fifo_wrapper;
    localparam int CPB = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rx = 1'b1, clr_cmd_rdy = 1'b0, trmt = 1'b0;
    logic [15:0] resp = '0;
    logic        tx, cmd_rdy, tx_done, resp_busy, cmd_ovf, rx_timeout;
    logic [15:0] cmd;

    logic        rx3 = 1'b1, clr3 = 1'b0;
    logic        tx3, cmd_rdy3, tx_done3, resp_busy3, cmd_ovf3, rx_timeout3;
    logic [23:0] cmd3;

    uart_cmd_fifo_wrapper #(
        .CMD_BYTES(2), .RESP_BYTES(2), .FIFO_DEPTH(2), .TIMEOUT_CLKS(1000), .CLKS_PER_BIT(CPB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy),
        .cmd(cmd), .trmt(trmt), .resp(resp), .tx_done(tx_done), .resp_busy(resp_busy),
        .cmd_ovf(cmd_ovf), .rx_timeout(rx_timeout)
    );

    uart_cmd_fifo_wrapper #(
        .CMD_BYTES(3), .RESP_BYTES(1), .FIFO_DEPTH(4), .TIMEOUT_CLKS(0), .CLKS_PER_BIT(CPB)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .RX(rx3), .TX(tx3), .clr_cmd_rdy(clr3), .cmd_rdy(cmd_rdy3),
        .cmd(cmd3), .trmt(1'b0), .resp(8'h00), .tx_done(tx_done3), .resp_busy(resp_busy3),
        .cmd_ovf(cmd_ovf3), .rx_timeout(rx_timeout3)
    );

    int checks = 0;
    int errors = 0;

    // pulse monitors count high cycles, so a stretched pulse shows up as an extra count
    int   ovf_cycles = 0, tmo_cycles = 0, rise3 = 0;
    logic prev3 = 1'b0;
    always @(negedge clk) begin
        if (cmd_ovf === 1'b1) ovf_cycles++;
        if (rx_timeout === 1'b1) tmo_cycles++;
        if (cmd_rdy3 === 1'b1 && !prev3) rise3++;
        prev3 = (cmd_rdy3 === 1'b1);
    end

    // scoreboard: expected TX bytes vs bytes decoded from the TX line
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    always begin : tx_mon
        logic [7:0] b;
        @(negedge clk);
        if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            obs_q.push_back(b);
        end
    end

    // driver tasks
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input bit to3, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (to3) rx3 = frame[i];
            else     rx  = frame[i];
            repeat (CPB) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(1'b0, b0);
        send_byte(1'b0, b1);
        cyc(4);
    endtask

    task automatic pop_check(input string name, input logic [15:0] exp);
        check({name, "_rdy"}, cmd_rdy, 1);
        check(name, cmd, exp);
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
    endtask

    // pop exactly in the cycle the final byte is pushed
    task automatic send_with_pop(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(1'b0, b0);
        fork
            send_byte(1'b0, b1);
            begin
                int n;
                n = 0;
                while (u_dut.uart_rx_rdy !== 1'b1 && n < 200) begin
                    cyc();
                    n++;
                end
                clr_cmd_rdy = 1'b1;
                cyc();
                clr_cmd_rdy = 1'b0;
            end
        join
        cyc(4);
    endtask

    task automatic do_resp(input logic [15:0] r, input logic [7:0] hi, input logic [7:0] lo,
                           input bit interrupt);
        int n;
        logic [7:0] act;
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        resp = r;
        trmt = 1'b1;
        cyc();
        trmt = 1'b0;
        resp = '0;
        check("busy_after_trmt", resp_busy, 1);
        check("tx_done_cleared", tx_done, 0);
        if (interrupt) begin
            cyc(50);
            resp = 16'hFFFF;
            trmt = 1'b1;
            cyc();
            trmt = 1'b0;
            resp = '0;
            check("busy_mid_resp", resp_busy, 1);
        end
        n = 0;
        while (tx_done !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        check("tx_done_set", tx_done, 1);
        check("busy_end", resp_busy, 0);
        cyc(60);
        check("resp_nbytes", obs_q.size(), exp_q.size());
        while (exp_q.size() != 0) begin
            act = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
            check("resp_byte", act, exp_q.pop_front());
        end
        obs_q.delete();
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_cmd;
    } cmd_vec_t;

    typedef struct {
        logic [15:0] r;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        bit          interrupt;
    } resp_vec_t;

    cmd_vec_t  cmd_tbl[4];
    resp_vec_t resp_tbl[3];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ovf0, tmo0;
        cmd_tbl[0] = '{8'h12, 8'h34, 16'h1234};
        cmd_tbl[1] = '{8'h00, 8'hFF, 16'h00FF};
        cmd_tbl[2] = '{8'hFF, 8'h00, 16'hFF00};
        cmd_tbl[3] = '{8'hC3, 8'h5A, 16'hC35A};
        resp_tbl[0] = '{16'h5AC3, 8'h5A, 8'hC3, 1'b0};
        resp_tbl[1] = '{16'h00FF, 8'h00, 8'hFF, 1'b1};
        resp_tbl[2] = '{16'h8001, 8'h80, 8'h01, 1'b0};

        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_resp_busy", resp_busy, 0);
        check("rst_cmd_ovf", cmd_ovf, 0);
        check("rst_rx_timeout", rx_timeout, 0);
        check("rst_tx_idle", tx, 1);
        check("rst_cmd_rdy3", cmd_rdy3, 0);

        for (int i = 0; i < 4; i++) begin
            send_cmd(cmd_tbl[i].b0, cmd_tbl[i].b1);
            pop_check("tbl_cmd", cmd_tbl[i].exp_cmd);
            check("tbl_empty", cmd_rdy, 0);
        end

        ovf0 = ovf_cycles;
        send_cmd(8'h11, 8'h11);
        send_cmd(8'h22, 8'h22);
        check("no_ovf_when_fits", ovf_cycles, ovf0);
        send_cmd(8'h33, 8'h33);
        check("ovf_pulse", ovf_cycles, ovf0 + 1);
        pop_check("ovf_head0", 16'h1111);
        pop_check("ovf_head1", 16'h2222);
        check("ovf_drained", cmd_rdy, 0);

        ovf0 = ovf_cycles;
        send_cmd(8'hAA, 8'h01);
        send_cmd(8'hBB, 8'h02);
        send_with_pop(8'hCC, 8'h03);
        check("full_pushpop_no_ovf", ovf_cycles, ovf0);
        pop_check("full_pushpop_h0", 16'hBB02);
        pop_check("full_pushpop_h1", 16'hCC03);
        check("full_pushpop_empty", cmd_rdy, 0);

        send_cmd(8'hDD, 8'h04);
        send_with_pop(8'hEE, 8'h05);
        pop_check("one_pushpop_head", 16'hEE05);
        check("one_pushpop_empty", cmd_rdy, 0);
        check("one_pushpop_no_ovf", ovf_cycles, ovf0);

        tmo0 = tmo_cycles;
        send_byte(1'b0, 8'hDE);
        cyc(900);
        check("tmo_not_early", tmo_cycles, tmo0);
        cyc(200);
        check("tmo_pulse", tmo_cycles, tmo0 + 1);
        check("tmo_no_cmd", cmd_rdy, 0);
        send_cmd(8'hBE, 8'hEF);
        pop_check("tmo_realign", 16'hBEEF);
        check("tmo_empty", cmd_rdy, 0);
        check("tmo_no_extra", tmo_cycles, tmo0 + 1);

        for (int i = 0; i < 3; i++)
            do_resp(resp_tbl[i].r, resp_tbl[i].exp_hi, resp_tbl[i].exp_lo, resp_tbl[i].interrupt);

        send_byte(1'b1, 8'hA5);
        send_byte(1'b1, 8'h3C);
        cyc(4);
        check("cmd3_not_early", rise3, 0);
        send_byte(1'b1, 8'h7E);
        cyc(4);
        check("cmd3_one_rise", rise3, 1);
        check("cmd3_word", cmd3, 24'hA53C7E);
        clr3 = 1'b1;
        cyc();
        clr3 = 1'b0;
        check("cmd3_popped", cmd_rdy3, 0);
        cyc(20);
        check("cmd3_still_one", rise3, 1);

        send_cmd(8'h77, 8'h77);
        send_byte(1'b0, 8'hAB);
        resp = 16'h1234;
        trmt = 1'b1;
        cyc();
        trmt = 1'b0;
        resp = '0;
        cyc(30);
        check("pre_rst_busy", resp_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_rdy", cmd_rdy, 0);
        check("mid_rst_busy", resp_busy, 0);
        check("mid_rst_tx_done", tx_done, 0);
        check("mid_rst_ovf", cmd_ovf, 0);
        check("mid_rst_tmo", rx_timeout, 0);
        check("mid_rst_tx", tx, 1);
        cyc(3);
        rst_n = 1'b1;
        cyc(200);
        obs_q.delete();
        check("post_rst_empty", cmd_rdy, 0);
        send_cmd(8'h12, 8'h34);
        pop_check("post_rst_cmd", 16'h1234);
        check("post_rst_drained", cmd_rdy, 0);
        check("post_rst_idle_tx", obs_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
